// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/add/compare plus shift-add MULU and restoring DIVU.
// Latency 1 edge for single-cycle/illegal/div-by-zero, WIDTH+1 edges for MULU/DIVU; start ignored unless IDLE.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zf,
    output logic             of,
    output logic             dz,
    output logic             ill
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [2*WIDTH-1:0]   acc_q, acc_nxt;
    logic [WIDTH-1:0]     opnd_q, opnd_nxt;
    logic                 is_div_q, is_div_nxt;

    logic                 out_we;
    logic [WIDTH-1:0]     lo_nxt, hi_nxt;
    logic                 of_nxt, dz_nxt, ill_nxt;

    // single-cycle datapath, fed straight from the inputs on the accepting edge
    logic [WIDTH-1:0]     sum, diff;
    logic                 add_of, sub_of;

    assign sum    = a + b;
    assign diff   = a - b;
    assign add_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    // one multiply iteration: conditional add into the upper half, carry shifts back in
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // one restoring-divide iteration; the shifted remainder needs WIDTH+1 bits
    logic [WIDTH:0]       div_shift, div_trial;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_step;

    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_step  = div_ge ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0]   iter;
    assign iter = is_div_q ? div_step : mul_step;

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        acc_nxt    = acc_q;
        opnd_nxt   = opnd_q;
        is_div_nxt = is_div_q;
        out_we     = 1'b0;
        lo_nxt     = '0;
        hi_nxt     = '0;
        of_nxt     = 1'b0;
        dz_nxt     = 1'b0;
        ill_nxt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    out_we    = 1'b1;
                    state_nxt = DONE;
                    case (op)
                        OP_AND:  lo_nxt = a & b;
                        OP_OR:   lo_nxt = a | b;
                        OP_ADD: begin
                            lo_nxt = sum;
                            of_nxt = add_of;
                        end
                        OP_SUB: begin
                            lo_nxt = diff;
                            of_nxt = sub_of;
                        end
                        OP_SLT:  lo_nxt = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_of};
                        OP_SLTU: lo_nxt = {{(WIDTH-1){1'b0}}, a < b};
                        OP_MULU: begin
                            out_we     = 1'b0;
                            state_nxt  = RUN;
                            cnt_nxt    = CNT_W'(WIDTH);
                            acc_nxt    = {{WIDTH{1'b0}}, b};
                            opnd_nxt   = a;
                            is_div_nxt = 1'b0;
                        end
                        OP_DIVU: begin
                            if (b == '0) begin
                                lo_nxt = '1;
                                hi_nxt = a;
                                dz_nxt = 1'b1;
                            end else begin
                                out_we     = 1'b0;
                                state_nxt  = RUN;
                                cnt_nxt    = CNT_W'(WIDTH);
                                acc_nxt    = {{WIDTH{1'b0}}, a};
                                opnd_nxt   = b;
                                is_div_nxt = 1'b1;
                            end
                        end
                        default: ill_nxt = 1'b1;
                    endcase
                end
            end
            RUN: begin
                acc_nxt = iter;
                cnt_nxt = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = DONE;
                    out_we    = 1'b1;
                    lo_nxt    = iter[WIDTH-1:0];
                    hi_nxt    = iter[2*WIDTH-1:WIDTH];
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            zf        <= 1'b0;
            of        <= 1'b0;
            dz        <= 1'b0;
            ill       <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            acc_q    <= acc_nxt;
            opnd_q   <= opnd_nxt;
            is_div_q <= is_div_nxt;
            if (out_we) begin
                result_lo <= lo_nxt;
                result_hi <= hi_nxt;
                zf        <= (lo_nxt == '0);
                of        <= of_nxt;
                dz        <= dz_nxt;
                ill       <= ill_nxt;
            end
        end
    end

endmodule
